// File: rtl/pc_gen.sv
// pc_gen -- program counter generator with a return-address stack.
//
// Picks the next fetch PC from (highest priority first) a trap vector, an
// EX-stage redirect, a stall hold, a return-address-stack prediction, or
// the sequential PC+4. Calls push PC+4 onto a small circular stack and
// returns pop it. Only trap/redirect can move the PC during a stall.
//
// Ports:
//   CLK           in   clock, all state updates on the rising edge
//   RST           in   asynchronous active-high reset
//   PC_WRITE      in   advance enable (0 = stall sequential/push/pop paths)
//   TRAP_VALID    in   trap redirect request
//   TRAP_VEC      in   trap target
//   REDIR_VALID   in   EX-stage branch/jump redirect request
//   REDIR_TARGET  in   redirect target
//   RAS_PUSH      in   fetched instruction is a call
//   RAS_POP       in   fetched instruction is a return
//   PC_COUNT      out  registered current PC
//   PC_NEXT       out  combinational value PC_COUNT takes at the next edge
//   MISALIGN      out  PC_COUNT[1:0] != 0
//   RAS_EMPTY     out  stack holds no entries
//   RAS_FULL      out  stack holds RAS_DEPTH entries
module pc_gen #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VEC = '0,
    parameter int                 RAS_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PC_WRITE,
    input  logic             TRAP_VALID,
    input  logic [WIDTH-1:0] TRAP_VEC,
    input  logic             REDIR_VALID,
    input  logic [WIDTH-1:0] REDIR_TARGET,
    input  logic             RAS_PUSH,
    input  logic             RAS_POP,
    output logic [WIDTH-1:0] PC_COUNT,
    output logic [WIDTH-1:0] PC_NEXT,
    output logic             MISALIGN,
    output logic             RAS_EMPTY,
    output logic             RAS_FULL
);

    // Top pointer spans exactly the entry array; count needs one more value
    // than that to represent "full".
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0]                  pc_q;
    logic [PW-1:0]                     top_q;
    logic [CW-1:0]                     cnt_q;
    logic [RAS_DEPTH-1:0][WIDTH-1:0]   ras_q;

    logic [WIDTH-1:0] pc_plus4;
    logic             qual;
    logic             do_push;
    logic             do_pop;
    logic             ras_empty;
    logic             ras_full;

    assign pc_plus4  = pc_q + WIDTH'(4);   // wraps silently
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_FULL);

    // Stack ops only happen on an advancing, non-redirected fetch.
    assign qual    = PC_WRITE & ~TRAP_VALID & ~REDIR_VALID;
    assign do_push = qual & RAS_PUSH;
    assign do_pop  = qual & RAS_POP & ~ras_empty;

    always_comb begin
        PC_NEXT = pc_plus4;
        if (TRAP_VALID)       PC_NEXT = TRAP_VEC;
        else if (REDIR_VALID) PC_NEXT = REDIR_TARGET;
        else if (!PC_WRITE)   PC_NEXT = pc_q;
        else if (do_pop)      PC_NEXT = ras_q[top_q];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= PC_NEXT;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            top_q <= '0;
            cnt_q <= '0;
            ras_q <= '0;
        end else if (do_push && do_pop) begin
            // Call and return in one fetch: the return consumes the top and
            // the call replaces it, so depth is unchanged.
            ras_q[top_q] <= pc_plus4;
        end else if (do_push) begin
            // When full, top+1 lands on the oldest entry and overwrites it.
            ras_q[top_q + PW'(1)] <= pc_plus4;
            top_q                 <= top_q + PW'(1);
            if (!ras_full) cnt_q  <= cnt_q + CW'(1);
        end else if (do_pop) begin
            top_q <= top_q - PW'(1);
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign PC_COUNT  = pc_q;
    assign MISALIGN  = |pc_q[1:0];
    assign RAS_EMPTY = ras_empty;
    assign RAS_FULL  = ras_full;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen (WIDTH=32, RESET_VEC=0, RAS_DEPTH=4): a directed vector
// table, hand-written overflow and async-reset sequences, and randomized
// traffic, all compared against a queue-based reference model.
module tb_pc_gen;

    logic        CLK = 1'b0;
    logic        RST;
    logic        PC_WRITE, TRAP_VALID, REDIR_VALID, RAS_PUSH, RAS_POP;
    logic [31:0] TRAP_VEC, REDIR_TARGET;
    logic [31:0] PC_COUNT, PC_NEXT;
    logic        MISALIGN, RAS_EMPTY, RAS_FULL;

    pc_gen #(.WIDTH(32), .RESET_VEC(32'h0), .RAS_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .PC_WRITE(PC_WRITE),
        .TRAP_VALID(TRAP_VALID), .TRAP_VEC(TRAP_VEC),
        .REDIR_VALID(REDIR_VALID), .REDIR_TARGET(REDIR_TARGET),
        .RAS_PUSH(RAS_PUSH), .RAS_POP(RAS_POP),
        .PC_COUNT(PC_COUNT), .PC_NEXT(PC_NEXT), .MISALIGN(MISALIGN),
        .RAS_EMPTY(RAS_EMPTY), .RAS_FULL(RAS_FULL)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: PC plus a queue of return addresses, newest at back.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];

    typedef struct {
        logic        pw, tv;
        logic [31:0] tvec;
        logic        rv;
        logic [31:0] rt;
        logic        push, pop;
        logic [31:0] exp_pc;
        logic        exp_empty, exp_full, exp_mis;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_q.delete();
    endtask

    // Drive one fetch cycle from a negedge, check PC_NEXT before the edge and
    // the registered outputs after it; returns at the following negedge.
    task automatic apply(input logic pw, input logic tv, input logic [31:0] tvec,
                         input logic rv, input logic [31:0] rt,
                         input logic push, input logic pop);
        logic [31:0] nxt;
        int          n;
        PC_WRITE = pw; TRAP_VALID = tv; TRAP_VEC = tvec;
        REDIR_VALID = rv; REDIR_TARGET = rt; RAS_PUSH = push; RAS_POP = pop;
        n = m_q.size();
        if (tv)                nxt = tvec;
        else if (rv)           nxt = rt;
        else if (!pw)          nxt = m_pc;
        else if (pop && n > 0) nxt = m_q[n-1];
        else                   nxt = m_pc + 32'd4;
        #1;
        check("pc_next", PC_NEXT, nxt);
        @(posedge CLK);
        if (pw && !tv && !rv) begin
            if (push && pop && n > 0) m_q[n-1] = m_pc + 32'd4;
            else if (push) begin
                m_q.push_back(m_pc + 32'd4);
                if (m_q.size() > 4) void'(m_q.pop_front());
            end else if (pop && n > 0) void'(m_q.pop_back());
        end
        m_pc = nxt;
        #1;
        check("pc_count", PC_COUNT, m_pc);
        check("ras_empty", {31'b0, RAS_EMPTY}, {31'b0, m_q.size() == 0});
        check("ras_full", {31'b0, RAS_FULL}, {31'b0, m_q.size() == 4});
        check("misalign", {31'b0, MISALIGN}, {31'b0, m_pc[1:0] != 2'b00});
        @(negedge CLK);
    endtask

    task automatic add(input logic pw, input logic tv, input logic [31:0] tvec,
                       input logic rv, input logic [31:0] rt, input logic push,
                       input logic pop, input logic [31:0] epc, input logic ee,
                       input logic ef, input logic em);
        vec_t v;
        v.pw = pw; v.tv = tv; v.tvec = tvec; v.rv = rv; v.rt = rt;
        v.push = push; v.pop = pop; v.exp_pc = epc;
        v.exp_empty = ee; v.exp_full = ef; v.exp_mis = em;
        tbl.push_back(v);
    endtask

    // Step with plain advance/push/pop and check the PC against a constant.
    task automatic seq(input logic push, input logic pop, input logic [31:0] epc,
                       input logic ef, input string name);
        apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, push, pop);
        check(name, PC_COUNT, epc);
        check({name, "_full"}, {31'b0, RAS_FULL}, {31'b0, ef});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; PC_WRITE = 1'b0; TRAP_VALID = 1'b0; TRAP_VEC = '0;
        REDIR_VALID = 1'b0; REDIR_TARGET = '0; RAS_PUSH = 1'b0; RAS_POP = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        check("rst_pc", PC_COUNT, 32'h0);
        check("rst_empty", {31'b0, RAS_EMPTY}, 32'd1);
        check("rst_full", {31'b0, RAS_FULL}, 32'd0);
        check("rst_mis", {31'b0, MISALIGN}, 32'd0);
        RST = 1'b0;

        //   pw tv tvec          rv rt            push pop exp_pc        E F M
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h4,         1, 0, 0);
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h8,         1, 0, 0);
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'hC,         1, 0, 0);
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h10,        1, 0, 0);
        add(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h10,        1, 0, 0);
        add(0, 0, 32'h0,        1, 32'h80,       0, 0, 32'h80,        1, 0, 0);
        add(0, 1, 32'h200,      1, 32'h80,       0, 0, 32'h200,       1, 0, 0);
        add(1, 0, 32'h0,        1, 32'h20,       0, 0, 32'h20,        1, 0, 0);
        add(1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h24,        0, 0, 0);
        add(1, 0, 32'h0,        1, 32'h100,      0, 0, 32'h100,       0, 0, 0);
        add(1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h24,        1, 0, 0);
        add(1, 0, 32'h0,        1, 32'h40,       0, 0, 32'h40,        1, 0, 0);
        add(1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h44,        1, 0, 0);
        add(1, 0, 32'h0,        1, 32'h50,       1, 0, 32'h50,        1, 0, 0);
        add(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h50,        1, 0, 0);
        add(1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h54,        0, 0, 0);
        add(1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h54,        0, 0, 0);
        add(1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h58,        1, 0, 0);
        add(1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 0, 0);
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,         1, 0, 0);
        add(1, 0, 32'h0,        1, 32'h2,        0, 0, 32'h2,         1, 0, 1);
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h6,         1, 0, 1);
        add(1, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,         1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].pw, tbl[i].tv, tbl[i].tvec, tbl[i].rv, tbl[i].rt,
                  tbl[i].push, tbl[i].pop);
            check($sformatf("tbl%0d_pc", i), PC_COUNT, tbl[i].exp_pc);
            check($sformatf("tbl%0d_empty", i), {31'b0, RAS_EMPTY}, {31'b0, tbl[i].exp_empty});
            check($sformatf("tbl%0d_full", i), {31'b0, RAS_FULL}, {31'b0, tbl[i].exp_full});
            check($sformatf("tbl%0d_mis", i), {31'b0, MISALIGN}, {31'b0, tbl[i].exp_mis});
        end

        // Overflow: five calls from PC 0, oldest entry (0x4) is lost.
        seq(1, 0, 32'h4,  0, "ovf_push1");
        seq(1, 0, 32'h8,  0, "ovf_push2");
        seq(1, 0, 32'hC,  0, "ovf_push3");
        seq(1, 0, 32'h10, 1, "ovf_push4");
        seq(1, 0, 32'h14, 1, "ovf_push5");
        seq(0, 1, 32'h14, 0, "ovf_pop1");
        seq(0, 1, 32'h10, 0, "ovf_pop2");
        seq(0, 1, 32'hC,  0, "ovf_pop3");
        seq(0, 1, 32'h8,  0, "ovf_pop4");
        seq(0, 1, 32'hC,  0, "ovf_pop5");
        check("ovf_empty", {31'b0, RAS_EMPTY}, 32'd1);

        // Async reset between edges with PC=0x88 and two stack entries.
        apply(1'b1, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("ar_pre_pc", PC_COUNT, 32'h88);
        check("ar_pre_empty", {31'b0, RAS_EMPTY}, 32'd0);
        #2 RST = 1'b1;
        #1;
        check("ar_pc", PC_COUNT, 32'h0);
        check("ar_empty", {31'b0, RAS_EMPTY}, 32'd1);
        // Reset dominates a trap across an edge.
        TRAP_VALID = 1'b1; TRAP_VEC = 32'h300;
        @(posedge CLK); #1;
        check("ar_dom_pc", PC_COUNT, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("ar_after_pc", PC_COUNT, 32'h4);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            apply($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, tgt,
                  $urandom_range(0, 7) == 0, {tgt[31:2], 2'b00} ^ 32'h40,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Parameters
REQ-001 WIDTH, default 32, SHALL set the PC and target width in bits; legal range is 8..64.
REQ-002 RESET_VEC, default 32'h0000_0000, SHALL be the PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-003 RAS_DEPTH, default 4, SHALL set the return-address-stack entry count; it SHALL be a power of 2 and at least 2.

Interface
REQ-004 CLK  in  1  SHALL be the sole clock; all state SHALL update on its rising edge.
REQ-005 RST  in  1  SHALL be an asynchronous, active-high reset.
REQ-006 PC_WRITE  in  1  SHALL be the advance enable; 0 SHALL stall the sequential, pop and push paths.
REQ-007 TRAP_VALID / TRAP_VEC  in  1 / WIDTH  SHALL be the trap redirect request and its target.
REQ-008 REDIR_VALID / REDIR_TARGET  in  1 / WIDTH  SHALL be the EX-stage branch/jump redirect and its target.
REQ-009 RAS_PUSH  in  1  SHALL mean the fetched instruction is a call; the pushed value is PC_COUNT+4.
REQ-010 RAS_POP  in  1  SHALL mean the fetched instruction is a return; the predicted target is the stack top.
REQ-011 PC_COUNT  out  WIDTH  SHALL be the registered current PC.
REQ-012 PC_NEXT  out  WIDTH  SHALL be the combinational value PC_COUNT takes at the next edge.
REQ-013 MISALIGN  out  1  SHALL be combinational and high when PC_COUNT[1:0] != 0.
REQ-014 RAS_EMPTY / RAS_FULL  out  1 / 1  SHALL be registered-state flags for a count of 0 and a count of RAS_DEPTH.

Function
REQ-015 PC_NEXT SHALL be selected by the first matching rule in this priority order: TRAP_VALID -> TRAP_VEC; REDIR_VALID -> REDIR_TARGET; !PC_WRITE -> PC_COUNT (hold); RAS_POP && !RAS_EMPTY -> stack top; otherwise PC_COUNT+4.
REQ-016 TRAP and REDIR SHALL override a stall: they load the PC even when PC_WRITE=0.
REQ-017 PC_COUNT+4 SHALL wrap modulo 2^WIDTH without a flag.
REQ-018 The stack SHALL be a circular buffer with a top pointer (log2 RAS_DEPTH bits) and a count (0..RAS_DEPTH).
REQ-019 A stack operation SHALL be qualified when PC_WRITE=1, TRAP_VALID=0 and REDIR_VALID=0; unqualified pushes and pops SHALL leave the stack unchanged.
REQ-020 Qualified push only: write PC_COUNT+4 at top+1; top increments; count saturates at RAS_DEPTH; a push when full SHALL overwrite the oldest entry.
REQ-021 Qualified pop only, not empty: top decrements; count decrements.
REQ-022 Qualified pop when empty: the stack SHALL be unchanged and PC_NEXT SHALL be PC_COUNT+4.
REQ-023 Qualified push and pop in the same cycle, not empty: PC_NEXT SHALL be the old top; the top entry SHALL be replaced by PC_COUNT+4; top and count SHALL be unchanged.
REQ-024 Qualified push and pop in the same cycle, empty: this SHALL be treated as push only, and PC_NEXT SHALL be PC_COUNT+4.
REQ-025 The latency from any input to PC_COUNT SHALL be exactly one clock edge; PC_NEXT SHALL have zero latency.
REQ-026 The stack SHALL never be consulted or modified by the trap or redirect paths, and no recovery of the stack on a redirect SHALL be performed.

Reset
REQ-027 While RST=1: PC_COUNT = RESET_VEC; stack top = 0; count = 0; all entries = 0; RAS_EMPTY = 1; RAS_FULL = 0.
REQ-028 RST SHALL act immediately, without waiting for CLK, including during a stall or mid-redirect.
REQ-029 RST SHALL dominate all other inputs, and the first edge after deassertion SHALL apply the normal rules.

Verification
REQ-030 Reset release, PC_WRITE=1, no other requests for 3 cycles -> PC_COUNT = 0, 4, 8, C.
REQ-031 Stall, then redirect and trap: PC=0x10, PC_WRITE=0 -> PC_COUNT holds 0x10; with PC_WRITE still 0 and REDIR_TARGET=0x80 -> PC_COUNT = 0x80; TRAP_VEC=0x200 asserted together with REDIR_VALID -> PC_COUNT = 0x200.
REQ-032 Call/return: at PC=0x20 RAS_PUSH, then redirect to 0x100, then RAS_POP at 0x100 -> PC_COUNT = 0x24 and RAS_EMPTY returns to 1.
REQ-033 Overflow with RAS_DEPTH=4: push at PCs 0x0, 0x4, 0x8, 0xC, 0x10 -> RAS_FULL = 1 after the 4th push; five pops return 0x14, 0x10, 0xC, 0x8, then the sequential PC.
REQ-034 Corner cases: pop while empty at 0x40 -> PC_COUNT = 0x44; WIDTH=32 with PC=0xFFFF_FFFC -> PC_COUNT = 0x0; push with REDIR_VALID=1 -> stack count unchanged.
REQ-035 Asynchronous reset mid-run: assert RST between clock edges with PC=0x88 and count=2 -> PC_COUNT = RESET_VEC and RAS_EMPTY = 1 before the next edge.
